// File: rtl/postfix_pkg.sv
// Shared constants for the postfix sequencer: ALU opcodes, ASCII tokens, error codes and FSM states.
package postfix_pkg;

  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_SUB = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_FULL  = 3'd2;
  localparam logic [2:0] ERR_CHAR  = 3'd3;
  localparam logic [2:0] ERR_END   = 3'd4;

  typedef enum logic [2:0] {
    FETCH, PA, PB, OP, WAIT, WB, DRAIN, DONE
  } state_e;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_ADD) || (c == CH_SUB) || (c == CH_MUL);
  endfunction

endpackage

// File: rtl/postfix_operand_stack.sv
// Operand stack register file: push at sp, replace stack[sp-2] while popping, combinational top/second/bottom reads.
module postfix_operand_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       repl_i,
  input  logic [WIDTH-1:0]           repl_data_i,
  input  logic                       clr_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [WIDTH-1:0]           second_o,
  output logic [WIDTH-1:0]           bottom_o,
  output logic [$clog2(DEPTH+1)-1:0] sp_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    top_idx, second_idx;

  always_comb begin
    sp_d = sp_q;
    if (clr_i)       sp_d = '0;
    else if (push_i) sp_d = sp_q + SPW'(1);
    else if (repl_i) sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Entries carry no reset: sp alone defines what is live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_i && (sp_q == SPW'(gi)))
        mem_q[gi] <= push_data_i;
      else if (repl_i && ((sp_q - SPW'(2)) == SPW'(gi)))
        mem_q[gi] <= repl_data_i;
    end
  end

  assign top_idx    = AW'(sp_q - SPW'(1));
  assign second_idx = AW'(sp_q - SPW'(2));
  assign top_o      = mem_q[top_idx];
  assign second_o   = mem_q[second_idx];
  assign bottom_o   = mem_q[0];
  assign sp_o       = sp_q;
  assign full_o     = (sp_q == SPW'(DEPTH));
  assign empty_o    = (sp_q == '0);

endmodule

// File: rtl/postfix_sequencer.sv
// Postfix expression controller: parses characters, keeps the operand stack and drives a
// latency-ALU_LAT stack ALU with push/push/op/pop per operator.
module postfix_sequencer
  import postfix_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [7:0]       tok_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic [2:0]       res_err,
  output logic             alu_strobe,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_data,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  output logic             busy
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int LW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d, mul_q, mul_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       err_q, err_d;
  logic [LW-1:0]    lat_q, lat_d;

  logic             stk_push, stk_repl, stk_clr, stk_full, stk_empty;
  logic [WIDTH-1:0] stk_top, stk_second, stk_bottom;
  logic [SPW-1:0]   sp;

  postfix_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (stk_push),
    .push_data_i (WIDTH'(tok_data[3:0])),
    .repl_i      (stk_repl),
    .repl_data_i (alu_out),
    .clr_i       (stk_clr),
    .top_o       (stk_top),
    .second_o    (stk_second),
    .bottom_o    (stk_bottom),
    .sp_o        (sp),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  assign tok_ready = (state_q == FETCH) || (state_q == DRAIN);
  assign busy      = !((state_q == FETCH) && stk_empty);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    mul_d      = mul_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    lat_d      = lat_q;
    stk_push   = 1'b0;
    stk_repl   = 1'b0;
    stk_clr    = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_ovf    = 1'b0;
    res_err    = ERR_NONE;
    alu_strobe = 1'b0;
    alu_opcode = 3'b000;
    alu_data   = '0;
    case (state_q)
      FETCH: begin
        if (tok_valid) begin
          if (is_digit(tok_data)) begin
            if (stk_full) begin
              err_d   = ERR_FULL;
              state_d = DRAIN;
            end else begin
              stk_push = 1'b1;
            end
          end else if (is_op(tok_data)) begin
            if (sp < SPW'(2)) begin
              err_d   = ERR_UNDER;
              state_d = DRAIN;
            end else begin
              a_d     = stk_second;
              b_d     = stk_top;
              sub_d   = (tok_data == CH_SUB);
              mul_d   = (tok_data == CH_MUL);
              state_d = PA;
            end
          end else if (tok_data == CH_NUL) begin
            if (sp != SPW'(1)) err_d = ERR_END;
            state_d = DONE;
          end else if (tok_data != CH_SP) begin
            err_d   = ERR_CHAR;
            state_d = DRAIN;
          end
        end
      end
      PA: begin
        alu_strobe = 1'b1;
        alu_opcode = OP_PUSH;
        alu_data   = a_q;
        state_d    = PB;
      end
      PB: begin
        // Subtraction is realised as A + (-B) on the adder.
        alu_strobe = 1'b1;
        alu_opcode = OP_PUSH;
        alu_data   = sub_q ? (~b_q + WIDTH'(1)) : b_q;
        state_d    = OP;
      end
      OP: begin
        alu_strobe = 1'b1;
        alu_opcode = mul_q ? OP_MUL : OP_ADD;
        lat_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (lat_q == LW'(ALU_LAT - 1)) state_d = WB;
        else                           lat_d   = lat_q + LW'(1);
      end
      WB: begin
        stk_repl   = 1'b1;
        ovf_d      = ovf_q | alu_ovf;
        alu_strobe = 1'b1;
        alu_opcode = OP_POP;
        state_d    = FETCH;
      end
      DRAIN: begin
        if (tok_valid && (tok_data == CH_NUL)) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        res_data  = (err_q == ERR_NONE) ? stk_bottom : '0;
        res_ovf   = ovf_q;
        res_err   = err_q;
        if (res_ready) begin
          stk_clr = 1'b1;
          ovf_d   = 1'b0;
          err_d   = ERR_NONE;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      mul_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= ERR_NONE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      mul_q   <= mul_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

endmodule
